// File: rtl/match_sequencer_pkg.sv
// Shared types and widths for the pong match sequencer: state encodings,
// score/timer widths, winner codes and the win-by-two helper.
package match_seq_pkg;

   localparam int SCORE_W = 4;
   localparam int TIMER_W = 8;
   localparam logic [SCORE_W-1:0] SCORE_MAX = 4'd15;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_RALLY = 3'd2,
      ST_POINT = 3'd3,
      ST_OVER  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      WIN_NONE  = 2'b00,
      WIN_LEFT  = 2'b01,
      WIN_RIGHT = 2'b10
   } winner_t;

   // One extra bit so theirs+2 cannot overflow at the 15 cap
   function automatic logic leads_by_two(input logic [SCORE_W-1:0] mine,
                                         input logic [SCORE_W-1:0] theirs);
      return {1'b0, mine} >= ({1'b0, theirs} + 5'd2);
   endfunction

endpackage

// File: rtl/match_sequencer_if.sv
// Frame/miss/start inputs and score/status outputs of the match sequencer.
interface match_sequencer_if;

   logic                              endofframe;
   logic [1:0]                        missed;
   logic                              isMoving;
   logic                              restart;
   logic                              serve_dir;
   logic [match_seq_pkg::SCORE_W-1:0] score_one;
   logic [match_seq_pkg::SCORE_W-1:0] score_two;
   logic [1:0]                        winner;
   logic [2:0]                        state_dbg;

   modport master (
      output endofframe, missed, isMoving,
      input  restart, serve_dir, score_one, score_two, winner, state_dbg
   );

   modport slave (
      input  endofframe, missed, isMoving,
      output restart, serve_dir, score_one, score_two, winner, state_dbg
   );

endinterface

// File: rtl/match_sequencer_frame_timer.sv
// Saturating frame down-counter used for the serve countdown and game-over hold.
module frame_timer
   import match_seq_pkg::*;
(
   input  logic               clk50M,
   input  logic               reset,
   input  logic               load,
   input  logic [TIMER_W-1:0] load_value,
   input  logic               endofframe,
   output logic               done
);

   logic [TIMER_W-1:0] count;

   always_ff @(posedge clk50M or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (endofframe && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/match_sequencer.sv
// Match-level FSM for pong: idle, serve countdown, rally, point, game over.
// Define MATCH_SEQ_DEUCE_EN for the win-by-two rule (hard win at 15).
module match_sequencer
   import match_seq_pkg::*;
#(
   parameter int                 WIN_SCORE    = 7,
   parameter logic [TIMER_W-1:0] SERVE_FRAMES = 8'd90,
   parameter logic [TIMER_W-1:0] OVER_FRAMES  = 8'd180
) (
   input logic               clk50M,
   input logic               reset,
   match_sequencer_if.slave  bus
);

   localparam logic [SCORE_W-1:0] WIN_TARGET = SCORE_W'(WIN_SCORE);

   state_t             state_q, state_d;
   logic [SCORE_W-1:0] score_one_q, score_one_d;
   logic [SCORE_W-1:0] score_two_q, score_two_d;
   logic               serve_dir_q, serve_dir_d;
   winner_t            winner_q, winner_d;
   logic               restart_q;
   logic               timer_load;
   logic [TIMER_W-1:0] timer_value;
   logic               timer_done;
   logic               left_won, right_won;

   frame_timer u_timer (
      .clk50M     (clk50M),
      .reset      (reset),
      .load       (timer_load),
      .load_value (timer_value),
      .endofframe (bus.endofframe),
      .done       (timer_done)
   );

`ifdef MATCH_SEQ_DEUCE_EN
   assign left_won  = (score_one_q == SCORE_MAX) ||
                      ((score_one_q >= WIN_TARGET) && leads_by_two(score_one_q, score_two_q));
   assign right_won = (score_two_q == SCORE_MAX) ||
                      ((score_two_q >= WIN_TARGET) && leads_by_two(score_two_q, score_one_q));
`else
   assign left_won  = (score_one_q >= WIN_TARGET);
   assign right_won = (score_two_q >= WIN_TARGET);
`endif

   // Next-state and next-register values; the serve points toward whoever conceded
   always_comb begin
      state_d     = state_q;
      score_one_d = score_one_q;
      score_two_d = score_two_q;
      serve_dir_d = serve_dir_q;
      winner_d    = winner_q;
      timer_load  = 1'b0;
      timer_value = SERVE_FRAMES;
      case (state_q)
         ST_IDLE: begin
            if (bus.endofframe && bus.isMoving) begin
               score_one_d = '0;
               score_two_d = '0;
               winner_d    = WIN_NONE;
               timer_load  = 1'b1;
               state_d     = ST_SERVE;
            end
         end
         ST_SERVE: begin
            if (bus.endofframe && timer_done) state_d = ST_RALLY;
         end
         ST_RALLY: begin
            if (bus.endofframe) begin
               case (bus.missed)
                  2'b01: begin
                     if (score_two_q != SCORE_MAX) score_two_d = score_two_q + 1'b1;
                     serve_dir_d = 1'b0;
                     state_d     = ST_POINT;
                  end
                  2'b10: begin
                     if (score_one_q != SCORE_MAX) score_one_d = score_one_q + 1'b1;
                     serve_dir_d = 1'b1;
                     state_d     = ST_POINT;
                  end
                  2'b11: begin
                     timer_load = 1'b1;
                     state_d    = ST_SERVE;
                  end
                  default: ;
               endcase
            end
         end
         ST_POINT: begin
            timer_load = 1'b1;
            if (left_won) begin
               winner_d    = WIN_LEFT;
               timer_value = OVER_FRAMES;
               state_d     = ST_OVER;
            end else if (right_won) begin
               winner_d    = WIN_RIGHT;
               timer_value = OVER_FRAMES;
               state_d     = ST_OVER;
            end else begin
               state_d     = ST_SERVE;
            end
         end
         ST_OVER: begin
            if (bus.endofframe && timer_done) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk50M or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         score_one_q <= '0;
         score_two_q <= '0;
         serve_dir_q <= 1'b0;
         winner_q    <= WIN_NONE;
         restart_q   <= 1'b1;
      end else begin
         state_q     <= state_d;
         score_one_q <= score_one_d;
         score_two_q <= score_two_d;
         serve_dir_q <= serve_dir_d;
         winner_q    <= winner_d;
         restart_q   <= (state_d != ST_RALLY);
      end
   end

   assign bus.restart   = restart_q;
   assign bus.serve_dir = serve_dir_q;
   assign bus.score_one = score_one_q;
   assign bus.score_two = score_two_q;
   assign bus.winner    = winner_q;
   assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed self-checking bench for match_sequencer with default frame counts.
module tb_match_sequencer;
   import match_seq_pkg::*;

   localparam int SERVE_N = 90;
   localparam int OVER_N  = 180;

   logic clk50M = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   match_sequencer_if bus ();

   always #10 clk50M = ~clk50M;

   match_sequencer #(
      .WIN_SCORE    (7),
      .SERVE_FRAMES (8'd90),
      .OVER_FRAMES  (8'd180)
   ) dut (
      .clk50M (clk50M),
      .reset  (reset),
      .bus    (bus.slave)
   );

   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic eof, input logic [1:0] m, input logic mv);
      @(negedge clk50M);
      bus.endofframe = eof;
      bus.missed     = m;
      bus.isMoving   = mv;
   endtask

   // One frame is a one-cycle strobe followed by three quiet cycles
   task automatic frames(input int n, input logic [1:0] m, input logic mv);
      repeat (n) begin
         applyStimulus(1'b1, m, mv);
         applyStimulus(1'b0, m, mv);
         applyStimulus(1'b0, m, mv);
         applyStimulus(1'b0, m, mv);
      end
   endtask

   task automatic checkStatus(input string tag, input state_t st, input logic rst,
                              input logic [7:0] s1, input logic [7:0] s2,
                              input winner_t win);
      checkOutput({tag, ".state"},   8'(bus.state_dbg), 8'(st));
      checkOutput({tag, ".restart"}, 8'(bus.restart),   8'(rst));
      checkOutput({tag, ".score1"},  8'(bus.score_one), s1);
      checkOutput({tag, ".score2"},  8'(bus.score_two), s2);
      checkOutput({tag, ".winner"},  8'(bus.winner),    8'(win));
   endtask

   // Called in RALLY; scores one point and, if play continues, returns in RALLY
   task automatic play_point(input logic [1:0] m, input logic [7:0] s1,
                             input logic [7:0] s2, input logic dir, input winner_t win);
      applyStimulus(1'b1, m, 1'b0);
      applyStimulus(1'b0, 2'b00, 1'b0);
      checkStatus("point", ST_POINT, 1'b1, s1, s2, WIN_NONE);
      @(negedge clk50M);
      checkOutput("after_point.state", 8'(bus.state_dbg),
                  8'((win == WIN_NONE) ? ST_SERVE : ST_OVER));
      checkOutput("after_point.winner", 8'(bus.winner), 8'(win));
      checkOutput("after_point.serve_dir", 8'(bus.serve_dir), 8'(dir));
      if (win == WIN_NONE) begin
         frames(SERVE_N + 1, 2'b00, 1'b0);
         checkOutput("rally.state", 8'(bus.state_dbg), 8'(ST_RALLY));
         checkOutput("rally.restart", 8'(bus.restart), 8'd0);
      end
   endtask

   initial begin
      reset          = 1'b1;
      bus.endofframe = 1'b0;
      bus.missed     = 2'b00;
      bus.isMoving   = 1'b0;
      repeat (3) @(negedge clk50M);
      checkStatus("reset", ST_IDLE, 1'b1, 8'd0, 8'd0, WIN_NONE);
      checkOutput("reset.serve_dir", 8'(bus.serve_dir), 8'd0);
      reset = 1'b0;

      frames(1, 2'b00, 1'b0);
      checkOutput("idle_no_start.state", 8'(bus.state_dbg), 8'(ST_IDLE));
      frames(1, 2'b00, 1'b1);
      checkStatus("start", ST_SERVE, 1'b1, 8'd0, 8'd0, WIN_NONE);
      frames(SERVE_N, 2'b00, 1'b0);
      checkStatus("serve_end", ST_SERVE, 1'b1, 8'd0, 8'd0, WIN_NONE);
      frames(1, 2'b00, 1'b0);
      checkStatus("first_rally", ST_RALLY, 1'b0, 8'd0, 8'd0, WIN_NONE);
      frames(1, 2'b00, 1'b0);
      checkOutput("rally_hold.state", 8'(bus.state_dbg), 8'(ST_RALLY));

      play_point(2'b01, 8'd0, 8'd1, 1'b0, WIN_NONE);

      // Let: no score change, serve countdown restarts in full
      applyStimulus(1'b1, 2'b11, 1'b0);
      applyStimulus(1'b0, 2'b00, 1'b0);
      checkStatus("let", ST_SERVE, 1'b1, 8'd0, 8'd1, WIN_NONE);
      frames(SERVE_N, 2'b01, 1'b1);
      checkStatus("stale_miss", ST_SERVE, 1'b1, 8'd0, 8'd1, WIN_NONE);
      frames(1, 2'b01, 1'b0);
      bus.missed = 2'b00;
      checkStatus("let_rally", ST_RALLY, 1'b0, 8'd0, 8'd1, WIN_NONE);

      for (int i = 1; i <= 6; i++) play_point(2'b10, 8'(i), 8'd1, 1'b1, WIN_NONE);
      play_point(2'b10, 8'd7, 8'd1, 1'b1, WIN_LEFT);
      frames(OVER_N, 2'b00, 1'b0);
      checkStatus("over_hold", ST_OVER, 1'b1, 8'd7, 8'd1, WIN_LEFT);
      frames(1, 2'b00, 1'b0);
      checkStatus("over_idle", ST_IDLE, 1'b1, 8'd7, 8'd1, WIN_LEFT);

      frames(1, 2'b00, 1'b1);
      checkStatus("restart_match", ST_SERVE, 1'b1, 8'd0, 8'd0, WIN_NONE);
      frames(SERVE_N + 1, 2'b00, 1'b0);
      checkOutput("match2_rally.state", 8'(bus.state_dbg), 8'(ST_RALLY));
`ifdef MATCH_SEQ_DEUCE_EN
      for (int i = 1; i <= 6; i++) begin
         play_point(2'b10, 8'(i), 8'(i - 1), 1'b1, WIN_NONE);
         play_point(2'b01, 8'(i), 8'(i), 1'b0, WIN_NONE);
      end
      play_point(2'b10, 8'd7, 8'd6, 1'b1, WIN_NONE);
      play_point(2'b10, 8'd8, 8'd6, 1'b1, WIN_LEFT);
`else
      for (int i = 1; i <= 6; i++) play_point(2'b01, 8'd0, 8'(i), 1'b0, WIN_NONE);
      play_point(2'b01, 8'd0, 8'd7, 1'b0, WIN_RIGHT);
`endif
      frames(5, 2'b00, 1'b0);
      checkOutput("mid_over.state", 8'(bus.state_dbg), 8'(ST_OVER));
      @(negedge clk50M);
      #2 reset = 1'b1;
      @(negedge clk50M);
      checkStatus("reset_over", ST_IDLE, 1'b1, 8'd0, 8'd0, WIN_NONE);
      checkOutput("reset_over.serve_dir", 8'(bus.serve_dir), 8'd0);
      reset = 1'b0;

`ifdef MATCH_SEQ_DEUCE_EN
      frames(1, 2'b00, 1'b1);
      frames(SERVE_N + 1, 2'b00, 1'b0);
      checkOutput("cap_rally.state", 8'(bus.state_dbg), 8'(ST_RALLY));
      for (int i = 1; i <= 14; i++) begin
         play_point(2'b10, 8'(i), 8'(i - 1), 1'b1, WIN_NONE);
         play_point(2'b01, 8'(i), 8'(i), 1'b0, WIN_NONE);
      end
      play_point(2'b10, 8'd15, 8'd14, 1'b1, WIN_LEFT);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
